// File: rtl/rootvoter_pkg.sv
// Shared rootvoter definitions: vote types, sequencer states and per-type
// dataset count, agreement threshold and compare-unit terminal count.
package rootvoter_pkg;

   typedef enum logic [1:0] {
      V2OO2 = 2'b00,
      V2OO3 = 2'b01,
      V4OO7 = 2'b10,
      V5OO9 = 2'b11
   } vote_type_e;

   typedef enum logic [2:0] {
      StIdle,
      StClr,
      StRun,
      StScan,
      StResp
   } seq_state_e;

   localparam int unsigned NumInputs = 9;

   // Active datasets N
   function automatic logic [3:0] vote_n(input vote_type_e vt);
      case (vt)
         V2OO2:   return 4'd2;
         V2OO3:   return 4'd3;
         V4OO7:   return 4'd7;
         default: return 4'd9;
      endcase
   endfunction

   // Required agreement count T
   function automatic logic [7:0] vote_t(input vote_type_e vt);
      case (vt)
         V2OO2:   return 8'd1;
         V2OO3:   return 8'd1;
         V4OO7:   return 8'd3;
         default: return 8'd4;
      endcase
   endfunction

   // Last compare index L; the compare unit is done after L+1 enabled cycles
   function automatic logic [7:0] vote_l(input vote_type_e vt);
      case (vt)
         V2OO2:   return 8'h01;
         V2OO3:   return 8'h02;
         V4OO7:   return 8'h14;
         default: return 8'h23;
      endcase
   endfunction

endpackage

// File: rtl/vote_sequencer.sv
// Sequences the dataset compare unit for one vote, then scans the agreement
// counts against the threshold and holds the verdict until it is consumed.
module vote_sequencer
   import rootvoter_pkg::*;
#(
   parameter int unsigned MAX_DATASETS = 9,
   parameter int unsigned TIMEOUT      = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] vote_type,
   input  logic       cmp_done,
   input  logic [7:0] res_A,
   input  logic [7:0] res_B,
   input  logic [7:0] res_C,
   input  logic [7:0] res_D,
   input  logic [7:0] res_E,
   input  logic [7:0] res_F,
   input  logic [7:0] res_G,
   input  logic [7:0] res_H,
   input  logic [7:0] res_I,
   output logic       cmp_reset,
   output logic       cmp_en,
   output logic       busy,
   output logic       result_valid,
   input  logic       result_ready,
   output logic [8:0] agree_mask,
   output logic [8:0] fault_mask,
   output logic [3:0] winner_idx,
   output logic       majority_ok,
   output logic       timeout_err,
   output logic       cfg_err
);

   seq_state_e state_q, state_d;
   vote_type_e vt_q, vt_d, vt_in;
   logic [7:0] tmo_cnt_q, tmo_cnt_d;
   logic [3:0] idx_q, idx_d;
   logic [8:0] agree_q, agree_d;
   logic [8:0] fault_q, fault_d;
   logic [3:0] winner_q, winner_d;
   logic       maj_q, maj_d;
   logic       tout_q, tout_d;
   logic       cfg_q, cfg_d;
   logic [7:0] counts [NumInputs];

   assign counts[0] = res_A;
   assign counts[1] = res_B;
   assign counts[2] = res_C;
   assign counts[3] = res_D;
   assign counts[4] = res_E;
   assign counts[5] = res_F;
   assign counts[6] = res_G;
   assign counts[7] = res_H;
   assign counts[8] = res_I;

   assign vt_in = vote_type_e'(vote_type);

   always_comb begin
      state_d   = state_q;
      vt_d      = vt_q;
      tmo_cnt_d = tmo_cnt_q;
      idx_d     = idx_q;
      agree_d   = agree_q;
      fault_d   = fault_q;
      winner_d  = winner_q;
      maj_d     = maj_q;
      tout_d    = tout_q;
      cfg_d     = cfg_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               vt_d     = vt_in;
               agree_d  = '0;
               fault_d  = '0;
               winner_d = 4'hF;
               maj_d    = 1'b0;
               tout_d   = 1'b0;
               cfg_d    = 1'b0;
               if (32'(vote_n(vt_in)) > MAX_DATASETS) begin
                  cfg_d   = 1'b1;
                  state_d = StResp;
               end else begin
                  state_d = StClr;
               end
            end
         end
         StClr: begin
            tmo_cnt_d = '0;
            state_d   = StRun;
         end
         StRun: begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
            if (cmp_done) begin
               idx_d   = '0;
               state_d = StScan;
            end else if (32'(tmo_cnt_q) + 32'd1 >= TIMEOUT) begin
               tout_d   = 1'b1;
               agree_d  = '0;
               fault_d  = '0;
               winner_d = 4'hF;
               state_d  = StResp;
            end
         end
         StScan: begin
            if (counts[idx_q] >= vote_t(vt_q)) begin
               agree_d[idx_q] = 1'b1;
               if (winner_q == 4'hF) winner_d = idx_q;
            end else begin
               fault_d[idx_q] = 1'b1;
            end
            if (idx_q == vote_n(vt_q) - 4'd1) begin
               maj_d   = |agree_d;
               state_d = StResp;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         StResp: begin
            if (result_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Compare unit has its own reset, so cmp_reset is purely the CLR decode
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         vt_q      <= V2OO2;
         tmo_cnt_q <= '0;
         idx_q     <= '0;
         agree_q   <= '0;
         fault_q   <= '0;
         winner_q  <= 4'hF;
         maj_q     <= 1'b0;
         tout_q    <= 1'b0;
         cfg_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         vt_q      <= vt_d;
         tmo_cnt_q <= tmo_cnt_d;
         idx_q     <= idx_d;
         agree_q   <= agree_d;
         fault_q   <= fault_d;
         winner_q  <= winner_d;
         maj_q     <= maj_d;
         tout_q    <= tout_d;
         cfg_q     <= cfg_d;
      end
   end

   assign cmp_reset    = (state_q == StClr);
   assign cmp_en       = (state_q == StRun) && !cmp_done;
   assign busy         = (state_q != StIdle);
   assign result_valid = (state_q == StResp);
   assign agree_mask   = agree_q;
   assign fault_mask   = fault_q;
   assign winner_idx   = winner_q;
   assign majority_ok  = maj_q;
   assign timeout_err  = tout_q;
   assign cfg_err      = cfg_q;

endmodule

// File: tb/tb_vote_sequencer.sv
// Bench for vote_sequencer: a default instance driven from a vector table with a
// compare-unit model, plus a short-timeout instance and a 3-dataset instance.
module tb_vote_sequencer;

   typedef struct {
      logic [1:0]       vt;
      logic [8:0][7:0]  cnt;       // {I,H,G,F,E,D,C,B,A}
      int               done_at;   // L+1 enabled cycles before done
      logic [8:0]       agree;
      logic [8:0]       fault;
      logic [3:0]       win;
      logic             maj;
      int               cyc;       // first result_valid cycle
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   vec_t vecs[6];
   vec_t sb[$];

   // Default instance
   logic            start_a = 1'b0, ready_a = 1'b1;
   logic [1:0]      vtype_a = 2'b00;
   logic [8:0][7:0] cnt_a = '0;
   logic            cmp_done_a, cmp_reset_a, cmp_en_a, busy_a, valid_a;
   logic [8:0]      agree_a, fault_a;
   logic [3:0]      win_a;
   logic            maj_a, tout_a, cfg_a;
   logic [7:0]      en_cnt = 8'd0;
   int              done_at = 0;

   vote_sequencer dut_a (
      .clk(clk), .reset(reset), .start(start_a), .vote_type(vtype_a),
      .cmp_done(cmp_done_a),
      .res_A(cnt_a[0]), .res_B(cnt_a[1]), .res_C(cnt_a[2]), .res_D(cnt_a[3]),
      .res_E(cnt_a[4]), .res_F(cnt_a[5]), .res_G(cnt_a[6]), .res_H(cnt_a[7]),
      .res_I(cnt_a[8]),
      .cmp_reset(cmp_reset_a), .cmp_en(cmp_en_a), .busy(busy_a),
      .result_valid(valid_a), .result_ready(ready_a),
      .agree_mask(agree_a), .fault_mask(fault_a), .winner_idx(win_a),
      .majority_ok(maj_a), .timeout_err(tout_a), .cfg_err(cfg_a)
   );

   // Compare-unit model: done once done_at enabled cycles have elapsed since clear
   always @(posedge clk) begin
      if (reset || cmp_reset_a) en_cnt <= 8'd0;
      else if (cmp_en_a)        en_cnt <= en_cnt + 8'd1;
   end
   assign cmp_done_a = (done_at != 0) && (int'(en_cnt) >= done_at);

   // Short-timeout instance, compare unit never finishes
   logic       start_t = 1'b0, ready_t = 1'b1, cmp_done_t = 1'b0;
   logic [1:0] vtype_t = 2'b00;
   logic [7:0] zero8 = 8'd0;
   logic       cmp_reset_t, cmp_en_t, busy_t, valid_t, maj_t, tout_t, cfg_t;
   logic [8:0] agree_t, fault_t;
   logic [3:0] win_t;

   vote_sequencer #(.MAX_DATASETS(9), .TIMEOUT(10)) dut_t (
      .clk(clk), .reset(reset), .start(start_t), .vote_type(vtype_t),
      .cmp_done(cmp_done_t),
      .res_A(zero8), .res_B(zero8), .res_C(zero8), .res_D(zero8), .res_E(zero8),
      .res_F(zero8), .res_G(zero8), .res_H(zero8), .res_I(zero8),
      .cmp_reset(cmp_reset_t), .cmp_en(cmp_en_t), .busy(busy_t),
      .result_valid(valid_t), .result_ready(ready_t),
      .agree_mask(agree_t), .fault_mask(fault_t), .winner_idx(win_t),
      .majority_ok(maj_t), .timeout_err(tout_t), .cfg_err(cfg_t)
   );

   // Three-dataset instance for the configuration error path
   logic       start_c = 1'b0, ready_c = 1'b0, cmp_done_c = 1'b0;
   logic [1:0] vtype_c = 2'b00;
   logic       cmp_reset_c, cmp_en_c, busy_c, valid_c, maj_c, tout_c, cfg_c;
   logic [8:0] agree_c, fault_c;
   logic [3:0] win_c;

   vote_sequencer #(.MAX_DATASETS(3), .TIMEOUT(64)) dut_c (
      .clk(clk), .reset(reset), .start(start_c), .vote_type(vtype_c),
      .cmp_done(cmp_done_c),
      .res_A(zero8), .res_B(zero8), .res_C(zero8), .res_D(zero8), .res_E(zero8),
      .res_F(zero8), .res_G(zero8), .res_H(zero8), .res_I(zero8),
      .cmp_reset(cmp_reset_c), .cmp_en(cmp_en_c), .busy(busy_c),
      .result_valid(valid_c), .result_ready(ready_c),
      .agree_mask(agree_c), .fault_mask(fault_c), .winner_idx(win_c),
      .majority_ok(maj_c), .timeout_err(tout_c), .cfg_err(cfg_c)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_a(input string tag);
      check({tag, "_cmp_reset"}, cmp_reset_a, 0);
      check({tag, "_cmp_en"}, cmp_en_a, 0);
      check({tag, "_busy"}, busy_a, 0);
      check({tag, "_valid"}, valid_a, 0);
      check({tag, "_agree"}, agree_a, 0);
      check({tag, "_fault"}, fault_a, 0);
      check({tag, "_winner"}, win_a, 4'hF);
      check({tag, "_maj"}, maj_a, 0);
      check({tag, "_tout"}, tout_a, 0);
      check({tag, "_cfg"}, cfg_a, 0);
   endtask

   // Runs one vote on dut_a; called #1 after a posedge with dut_a idle
   task automatic run_a(input vec_t v, input int hold, input bit poke);
      vec_t e;
      int   cyc, rst_cnt, rst_cyc;
      bit   found;
      cnt_a   = v.cnt;
      done_at = v.done_at;
      ready_a = (hold == 0);
      sb.push_back(v);
      vtype_a = v.vt;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      cyc = 1; found = 0; rst_cnt = 0; rst_cyc = -1;
      while (!found && cyc < 200) begin
         if (cmp_reset_a) begin rst_cnt++; rst_cyc = cyc; end
         if (valid_a) found = 1;
         else begin
            start_a = poke && (cyc == 3 || cyc == 4);
            vtype_a = poke ? 2'b11 : v.vt;
            @(posedge clk); #1;
            cyc++;
         end
      end
      start_a = 1'b0;
      check("valid_seen", found, 1);
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
         return;
      end
      e = sb.pop_front();
      check("valid_cycle", cyc, e.cyc);
      check("cmp_reset_pulses", rst_cnt, 1);
      check("cmp_reset_cycle", rst_cyc, 1);
      check("agree", agree_a, e.agree);
      check("fault", fault_a, e.fault);
      check("winner", win_a, e.win);
      check("majority", maj_a, e.maj);
      check("timeout_err", tout_a, 0);
      check("cfg_err", cfg_a, 0);
      check("busy_resp", busy_a, 1);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check("hold_valid", valid_a, 1);
         check("hold_agree", agree_a, e.agree);
         check("hold_fault", fault_a, e.fault);
         check("hold_winner", win_a, e.win);
         check("hold_maj", maj_a, e.maj);
      end
      ready_a = 1'b1;
      @(posedge clk); #1;
      check("valid_after_hs", valid_a, 0);
      check("busy_after_hs", busy_a, 0);
      check("agree_kept_idle", agree_a, e.agree);
      check("winner_kept_idle", win_a, e.win);
   endtask

   initial begin
      int  cyc, en_first, en_last, en_n, pulses;
      bit  found;

      vecs[0] = '{2'b00, {8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1},
                  2, 9'h001, 9'h002, 4'h0, 1'b1, 7};
      vecs[1] = '{2'b01, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd2, 8'd2, 8'd2},
                  3, 9'h007, 9'h000, 4'h0, 1'b1, 9};
      vecs[2] = '{2'b10, {8'd0, 8'd0, 8'd4, 8'd0, 8'd4, 8'd1, 8'd4, 8'd4, 8'd4},
                  21, 9'h057, 9'h028, 4'h0, 1'b1, 31};
      vecs[3] = '{2'b11, {8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2},
                  36, 9'h000, 9'h1FF, 4'hF, 1'b0, 48};
      vecs[4] = '{2'b11, {8'd4, 8'd4, 8'd4, 8'd3, 8'd4, 8'd255, 8'd4, 8'd0, 8'd3},
                  36, 9'h1DC, 9'h023, 4'h2, 1'b1, 48};
      vecs[5] = '{2'b10, {8'd9, 8'd9, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                  21, 9'h040, 9'h03F, 4'h6, 1'b1, 31};

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check_reset_a("reset");
      check("reset_t_busy", busy_t, 0);
      check("reset_c_winner", win_c, 4'hF);

      for (int i = 0; i < 6; i++) run_a(vecs[i], 0, 1'b0);

      // Consumer stalls five cycles
      run_a(vecs[2], 5, 1'b0);
      // Start pulses during RUN must not disturb a 2oo3 vote
      run_a(vecs[1], 0, 1'b1);

      // Reset in the middle of a 5oo9 scan
      cnt_a   = vecs[3].cnt;
      done_at = vecs[3].done_at;
      vtype_a = 2'b11;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (41) @(posedge clk);
      #1;
      check("midscan_busy", busy_a, 1);
      check("midscan_cmp_en", cmp_en_a, 0);
      check("midscan_valid", valid_a, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_reset_a("midscan");
      run_a(vecs[0], 0, 1'b0);

      // Timeout path with TIMEOUT=10
      vtype_t = 2'b00;
      start_t = 1'b1;
      cyc = 0; found = 0; en_first = -1; en_last = -1; en_n = 0;
      while (!found && cyc < 100) begin
         if (cmp_en_t) begin
            if (en_first < 0) en_first = cyc;
            en_last = cyc;
            en_n++;
         end
         if (valid_t) found = 1;
         else begin
            @(posedge clk); #1;
            start_t = 1'b0;
            cyc++;
         end
      end
      check("tmo_valid_seen", found, 1);
      check("tmo_valid_cycle", cyc, 12);
      check("tmo_en_first", en_first, 2);
      check("tmo_en_last", en_last, 11);
      check("tmo_en_cycles", en_n, 10);
      check("tmo_err", tout_t, 1);
      check("tmo_agree", agree_t, 0);
      check("tmo_fault", fault_t, 0);
      check("tmo_winner", win_t, 4'hF);
      check("tmo_maj", maj_t, 0);
      check("tmo_cfg", cfg_t, 0);
      @(posedge clk); #1;
      check("tmo_valid_after_hs", valid_t, 0);

      // Configuration error: 4oo7 on a 3-dataset build
      vtype_c = 2'b10;
      start_c = 1'b1;
      cyc = 0; found = 0; pulses = 0;
      while (!found && cyc < 20) begin
         if (cmp_reset_c || cmp_en_c) pulses++;
         if (valid_c) found = 1;
         else begin
            @(posedge clk); #1;
            start_c = 1'b0;
            cyc++;
         end
      end
      check("cfg_valid_seen", found, 1);
      check("cfg_valid_cycle", cyc, 1);
      check("cfg_err", cfg_c, 1);
      check("cfg_tout", tout_c, 0);
      check("cfg_agree", agree_c, 0);
      check("cfg_fault", fault_c, 0);
      check("cfg_winner", win_c, 4'hF);
      check("cfg_maj", maj_c, 0);
      @(posedge clk); #1;
      if (cmp_reset_c || cmp_en_c) pulses++;
      check("cfg_hold_valid", valid_c, 1);
      ready_c = 1'b1;
      @(posedge clk); #1;
      if (cmp_reset_c || cmp_en_c) pulses++;
      check("cfg_valid_after_hs", valid_c, 0);
      check("cfg_kept_idle", cfg_c, 1);
      check("cfg_cmp_pulses", pulses, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
